instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of single_cycle_processor and supplies its 32-bit instruction input.
- Holds the program counter (PC).
- Fetches words from an external instruction memory over a req/ack handshake with variable latency.
- Presents each instruction to the processor with a valid/ready handshake.
- Computes the next PC from the consumer's branch, zero and jump feedback.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_LAT_MAX, 16, ack timeout in cycles; on expiry, imem_err pulses and the request is retried

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  instruction memory request
imem_addr  out  32  word-aligned fetch address (PC)
imem_ack  in  1  single-cycle ack; imem_rdata valid in the same cycle
imem_rdata  in  32  fetched instruction word
imem_err  out  1  one-cycle pulse on ack timeout
instr  out  32  instruction to the processor
instr_valid  out  1  instr is valid
instr_ready  in  1  processor consumes instr this cycle
branch  in  1  consumer's branch decode for the current instr
zero  in  1  consumer's ALU zero flag for the current instr
jump  in  1  consumer's jump decode for the current instr
pc  out  32  PC of the instruction currently held/fetched

Behaviour:
- Reset (reset==0, async): state=FETCH_IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, imem_err=0, timeout counter=0.
- FSM states:
  - FETCH_IDLE: one cycle after reset release, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc held stable until ack.
    - imem_ack=1 at a rising edge: capture imem_rdata into instr, set instr_valid=1, drop imem_req, go to HOLD.
    - Otherwise increment the timeout counter.
    - Counter reaches MEM_LAT_MAX-1 without ack: pulse imem_err for 1 cycle, clear the counter, stay in REQ (retry, same address).
  - HOLD: instr and instr_valid held stable until instr_ready=1. On the handshake edge:
    - next pc = jump target if jump=1.
    - Else branch target if branch=1 and zero=1.
    - Else pc+4.
    - Then instr_valid=0, go to REQ.
- Next-PC arithmetic, 32-bit with silent wrap-around (pc=32'hFFFF_FFFC +4 -> 0):
  - pc4 = pc+4.
  - Branch target = pc4 + (sign-extended instr[15:0] << 2).
  - Jump target = {pc4[31:28], instr[25:0], 2'b00}.
- Simultaneous jump=1 and branch=1: jump wins.
- branch, zero and jump are sampled only on the handshake edge and ignored otherwise.
- Latency: ack edge -> instr_valid=1 the next cycle. Ready edge -> imem_req=1 the next cycle. Minimum 2 cycles per instruction with zero-wait memory.
- imem_ack outside REQ is ignored, with no state change.
- Reset asserted mid-request: imem_req drops immediately (async). A late ack arriving after reset release while in FETCH_IDLE is ignored.
- imem_addr[1:0] is always 2'b00. A RESET_PC with nonzero low bits is forced aligned.
- pc output equals the address of the instruction in instr while in HOLD, and the fetch address while in REQ.

Optional Feature:
IFU_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt[15:0].
  - Increments each cycle in REQ without ack, and each cycle in HOLD with instr_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory acks after 1 cycle -> imem_req=1 with imem_addr=0 the cycle after FETCH_IDLE; instr_valid=1 carrying the memory word one cycle after ack; pc=0.
- Sequential stream, instr_ready always 1, zero-wait memory -> addresses 0,4,8,12 fetched, each instruction valid every 2 cycles, no imem_err.
- Branch at pc=0x10, instr[15:0]=16'hFFFC, branch=1, zero=1 at handshake -> next imem_addr=0x04. Same case with zero=0 -> 0x14.
- Jump at pc=0x3000_0020, instr[25:0]=26'h0000040, jump=1, branch=1, zero=1 -> next imem_addr=0x3000_0100 (jump priority).
- Memory never acks, MEM_LAT_MAX=4 -> imem_err pulses every 4 cycles, imem_addr stable, instr_valid stays 0. Ack then given -> normal capture.
- Reset asserted while imem_req=1, then an ack arrives 1 cycle after release -> ack ignored, pc=RESET_PC, instr_valid=0, new request issued normally.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, valid/ready hand-off, next-PC
// Optional feature macro: IFU_STALL_CNT_EN (adds the stall_cnt[15:0] output)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LAT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
`ifdef IFU_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    REQ        = 2'd1,
    HOLD       = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [15:0] TMO_LAST         = 16'(MEM_LAT_MAX - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_r;
  logic [31:0] pc_next;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [15:0] tmo_cnt;
  logic        ack_take;
  logic        tmo_hit;
  logic        handshake;

  // Next-PC arithmetic; plain 32-bit adds so wrap-around is silent.
  always_comb begin
    pc4    = pc_r + 32'd4;
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_tgt = pc4 + br_off;
    j_tgt  = {pc4[31:28], instr[25:0], 2'b00};
    if (jump) begin
      pc_next = j_tgt;
    end else if (branch && zero) begin
      pc_next = br_tgt;
    end else begin
      pc_next = pc4;
    end
  end

  // State register; reset drops imem_req immediately because it decodes from state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; acks outside REQ never reach any state.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ack_take   = 1'b0;
    tmo_hit    = 1'b0;
    handshake  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ack_take   = 1'b1;
          state_next = HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          handshake  = 1'b1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
  end

  // Datapath registers: PC, captured instruction, valid flag, timeout counter and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r        <= RESET_PC_ALIGNED;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_err    <= 1'b0;
      tmo_cnt     <= 16'h0;
    end else begin
      imem_err <= tmo_hit;
      if (ack_take) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        tmo_cnt     <= 16'h0;
      end else if (tmo_hit) begin
        tmo_cnt <= 16'h0;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= 16'h0;
      end
      if (handshake) begin
        pc_r        <= {pc_next[31:2], 2'b00};
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Saturating count of cycles spent waiting on memory or on the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0;
    end else if (((state == REQ) && !imem_ack) || ((state == HOLD) && !instr_ready)) begin
      if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

  assign imem_addr = {pc_r[31:2], 2'b00};
  assign pc        = pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] pc;

  logic        rst2 = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        err2;
  logic [31:0] instr2;
  logic        valid2;
  logic        ready2 = 1'b0;
  logic        br2 = 1'b0;
  logic        z2 = 1'b0;
  logic        j2 = 1'b0;
  logic [31:0] pc2;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall1;
  logic [15:0] stall2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_idx = 0;
  int last_hs = 0;
  int ack_cyc = -10;
  int force_cyc = -10;
  int wait_cnt = 0;
  bit cons_en = 1'b0;
  bit release_tmo = 1'b0;
  bit after_rst = 1'b0;
  bit prev_valid = 1'b0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LAT_MAX(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .zero(zero), .jump(jump),
`ifdef IFU_STALL_CNT_EN
    .stall_cnt(stall1),
`endif
    .pc(pc)
  );

  instr_fetch_unit #(.RESET_PC(32'h3000_0022), .MEM_LAT_MAX(16)) dut2 (
    .clk(clk), .reset(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .imem_err(err2),
    .instr(instr2), .instr_valid(valid2), .instr_ready(ready2),
    .branch(br2), .zero(z2), .jump(j2),
`ifdef IFU_STALL_CNT_EN
    .stall_cnt(stall2),
`endif
    .pc(pc2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1000_FFFC;
    return a ^ 32'h5A5A_0000;
  endfunction

  // {branch, zero, jump} presented at handshake number idx
  function automatic logic [2:0] ctl_of(input int idx);
    case (idx)
      4:       return 3'b110;
      8:       return 3'b100;
      10:      return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Hand-derived fetch addresses for the first handshakes
  function automatic logic [31:0] tbl(input int idx);
    case (idx)
      0: return 32'h0;    1: return 32'h4;    2: return 32'h8;    3: return 32'hC;
      4: return 32'h10;   5: return 32'h4;    6: return 32'h8;    7: return 32'hC;
      8: return 32'h10;   9: return 32'h14;   10: return 32'h18;
      default: return 32'h0968_0060;
    endcase
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] p, input logic [31:0] w, input logic [2:0] c);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (c[0]) return {p4[31:28], w[25:0], 2'b00};
    if (c[2] && c[1]) return p4 + {{14{w[15]}}, w[15:0], 2'b00};
    return p4;
  endfunction

  // Memory model for dut: variable latency, scripted silent and forced-ack windows
  always @(negedge clk) begin
    bit noack;
    int dly;
    noack = (hs_idx >= 14) && !(release_tmo && hs_idx == 14) && !after_rst;
    if (cyc == force_cyc) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req && !imem_ack && !noack) begin
      dly = (hs_idx == 0) ? 1 : ((hs_idx >= 11) ? 2 : 0);
      if (wait_cnt >= dly) begin
        if (exp_q.size() != 0) chk("fetch_addr", imem_addr, exp_q[0]);
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        ack_cyc    = cyc;
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  // Consumer: handshakes, scoreboard pop/compare, pushes the next expected fetch address
  always @(negedge clk) begin
    bit rdy;
    logic [2:0] c;
    logic [31:0] ea;
    if (!cons_en) begin
      instr_ready = 1'b0;
      {branch, zero, jump} = 3'b000;
      prev_valid = instr_valid;
    end else begin
      if (instr_valid && !prev_valid) chk("ack_to_valid", 32'(cyc), 32'(ack_cyc + 1));
      prev_valid = instr_valid;
      rdy = (hs_idx <= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      if (instr_valid && rdy) begin
        c = ctl_of(hs_idx);
        {branch, zero, jump} = c;
        instr_ready = 1'b1;
        ea = 32'h0;
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          ea = exp_q.pop_front();
          chk("pc", pc, ea);
          chk("instr", instr, word(ea));
        end
        if (hs_idx < 14) chk("no_err", {31'b0, imem_err}, 32'd0);
        if (hs_idx >= 1 && hs_idx <= 9) chk("period", 32'(cyc - last_hs), 32'd2);
        last_hs = cyc;
        exp_q.push_back((hs_idx + 1 <= 11) ? tbl(hs_idx + 1) : nxt(ea, word(ea), c));
        hs_idx++;
      end else begin
        instr_ready = 1'b0;
        {branch, zero, jump} = 3'($urandom_range(0, 7));
      end
    end
  end

  task automatic wait_idx(input int n, input string tag);
    int k;
    k = 0;
    while (hs_idx < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (hs_idx < n) chk(tag, 32'(hs_idx), 32'(n));
  endtask

  initial begin
    int k;
    int pulses;
    int last_err;
    bit addr_ok;
    bit valid_ok;
    bit req_ok;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", {31'b0, imem_err}, 32'd0);

    // release; one idle cycle then a request at RESET_PC
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    cons_en = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // stream, branch taken/not taken, jump priority, stalls with random ready
    wait_idx(14, "stream_timeout");

    // silent memory: error pulses every 4 cycles, address held, nothing valid
    @(negedge clk);
    pulses = 0; last_err = -1; addr_ok = 1; valid_ok = 1; req_ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (imem_err) begin
        if (last_err >= 0) chk("tmo_gap", 32'(cyc - last_err), 32'd4);
        last_err = cyc;
        pulses++;
      end
      if (exp_q.size() == 0 || imem_addr !== exp_q[0]) addr_ok = 0;
      if (instr_valid !== 1'b0) valid_ok = 0;
      if (imem_req !== 1'b1) req_ok = 0;
      @(negedge clk);
    end
    chk("tmo_pulses", {31'b0, pulses >= 4}, 32'd1);
    chk("tmo_addr_stable", {31'b0, addr_ok}, 32'd1);
    chk("tmo_no_valid", {31'b0, valid_ok}, 32'd1);
    chk("tmo_req_held", {31'b0, req_ok}, 32'd1);
    release_tmo = 1'b1;
    wait_idx(15, "retry_timeout");

    // reset during an outstanding request, then a late ack in the idle cycle
    k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    cons_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_req_drop", {31'b0, imem_req}, 32'd0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    after_rst = 1'b1;
    force_cyc = cyc + 1;
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    cons_en = 1'b1;
    @(negedge clk);
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    wait_idx(18, "post_rst_timeout");

    // second instance: unaligned RESET_PC and jump beating a taken branch
    @(negedge clk);
    rst2 = 1'b1;
    k = 0;
    while (req2 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("d2_req", {31'b0, req2}, 32'd1);
    chk("d2_addr_aligned", addr2, 32'h3000_0020);
    chk("d2_pc_aligned", pc2, 32'h3000_0020);
    ack2 = 1'b1;
    rdata2 = 32'h0800_0040;
    @(negedge clk);
    ack2 = 1'b0;
    chk("d2_valid", {31'b0, valid2}, 32'd1);
    chk("d2_instr", instr2, 32'h0800_0040);
    chk("d2_req_drop", {31'b0, req2}, 32'd0);
    ready2 = 1'b1; j2 = 1'b1; br2 = 1'b1; z2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0; j2 = 1'b0; br2 = 1'b0; z2 = 1'b0;
    chk("d2_jump_req", {31'b0, req2}, 32'd1);
    chk("d2_jump_addr", addr2, 32'h3000_0100);
    chk("d2_err", {31'b0, err2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
